// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: IR remote decoding, MANUAL/AUTO/DANCE modes, obstacle brake.
// Optional feature: define BRAKE_HOLD_EN to hold the brake BRAKE_HOLD_CYCLES after the obstacle clears.
module drive_cmd_arbiter #(
   parameter int DANCE_STEP_CYCLES     = 50000000,
   parameter int MANUAL_TIMEOUT_CYCLES = 25000000,
   parameter int BRAKE_HOLD_CYCLES     = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ir_valid,
   input  logic [6:0] ir_cmd,
   input  logic       car_break_signal,
   input  logic       left_line_signal,
   input  logic       right_line_signal,
   output logic       mv_fwd,
   output logic       mv_back,
   output logic       turn_left,
   output logic       turn_right,
   output logic [1:0] mode,
   output logic       brake_active
);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_AUTO   = 2'b01,
      ST_DANCE  = 2'b10
   } state_t;

   localparam int TO_W = (MANUAL_TIMEOUT_CYCLES > 1) ? $clog2(MANUAL_TIMEOUT_CYCLES) : 1;
   localparam int ST_W = (DANCE_STEP_CYCLES > 1) ? $clog2(DANCE_STEP_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(MANUAL_TIMEOUT_CYCLES - 1);
   localparam logic [ST_W-1:0] STEP_LAST = ST_W'(DANCE_STEP_CYCLES - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [3:0]      r_dir;          // {fwd, back, left, right} latched in MANUAL
   logic [3:0]      w_dir_next;
   logic [TO_W-1:0] r_timeout;
   logic [TO_W-1:0] w_timeout_next;
   logic [1:0]      r_step;
   logic [1:0]      w_step_next;
   logic [ST_W-1:0] r_step_tmr;
   logic [ST_W-1:0] w_step_tmr_next;
   logic [3:0]      r_out;
   logic [3:0]      w_out_next;
   logic            r_brake;
   logic            w_brake_next;

   logic w_cmd_stop;
   logic w_cmd_auto;
   logic w_cmd_dance;
   logic w_cmd_dir;

   assign w_cmd_stop  = ir_valid & ir_cmd[6];
   assign w_cmd_auto  = ir_valid & ~ir_cmd[6] & ir_cmd[1];
   assign w_cmd_dance = ir_valid & ~ir_cmd[6] & ~ir_cmd[1] & ir_cmd[0];
   assign w_cmd_dir   = ir_valid & ~ir_cmd[6] & ~ir_cmd[1] & ~ir_cmd[0];

`ifdef BRAKE_HOLD_EN
   localparam int HOLD_W = (BRAKE_HOLD_CYCLES > 0) ? $clog2(BRAKE_HOLD_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BRAKE_HOLD_CYCLES);

   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_next;

   always_comb begin
      w_hold_next = r_hold_cnt;
      if (car_break_signal) begin
         w_hold_next = HOLD_LOAD;
      end else if (r_hold_cnt != '0) begin
         w_hold_next = r_hold_cnt - HOLD_W'(1);
      end
   end

   assign w_brake_next = car_break_signal | (r_hold_cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold_cnt <= '0;
      end else begin
         r_hold_cnt <= w_hold_next;
      end
   end
`else
   assign w_brake_next = car_break_signal;
`endif

   // Mode changes drop any stale manual direction so a return to MANUAL starts stationary.
   always_comb begin
      w_state_next    = r_state;
      w_dir_next      = r_dir;
      w_timeout_next  = r_timeout;
      w_step_next     = r_step;
      w_step_tmr_next = r_step_tmr;
      if (w_cmd_stop) begin
         w_state_next    = ST_MANUAL;
         w_dir_next      = 4'b0000;
         w_timeout_next  = '0;
         w_step_next     = 2'd0;
         w_step_tmr_next = '0;
      end else if (w_cmd_auto) begin
         w_state_next   = (r_state == ST_AUTO) ? ST_MANUAL : ST_AUTO;
         w_dir_next     = 4'b0000;
         w_timeout_next = '0;
      end else if (w_cmd_dance) begin
         w_state_next    = (r_state == ST_DANCE) ? ST_MANUAL : ST_DANCE;
         w_dir_next      = 4'b0000;
         w_timeout_next  = '0;
         w_step_next     = 2'd0;
         w_step_tmr_next = '0;
      end else begin
         case (r_state)
            ST_MANUAL: begin
               if (w_cmd_dir) begin
                  w_dir_next = {ir_cmd[5], ~ir_cmd[5] & ir_cmd[4],
                                ir_cmd[3], ~ir_cmd[3] & ir_cmd[2]};
                  w_timeout_next = '0;
               end else if (r_timeout == TO_LAST) begin
                  w_dir_next     = 4'b0000;
                  w_timeout_next = '0;
               end else begin
                  w_timeout_next = r_timeout + TO_W'(1);
               end
            end
            ST_DANCE: begin
               if (r_step_tmr == STEP_LAST) begin
                  w_step_tmr_next = '0;
                  w_step_next     = r_step + 2'd1;
               end else begin
                  w_step_tmr_next = r_step_tmr + ST_W'(1);
               end
            end
            ST_AUTO: begin
            end
            default: begin
               w_state_next = ST_MANUAL;
               w_dir_next   = 4'b0000;
            end
         endcase
      end
   end

   // Outputs are derived from the next-state values so every input shows up one clock later.
   always_comb begin
      w_out_next = 4'b0000;
      case (w_state_next)
         ST_MANUAL: w_out_next = w_dir_next;
         ST_AUTO: begin
            case ({left_line_signal, right_line_signal})
               2'b00:   w_out_next = 4'b1000;
               2'b10:   w_out_next = 4'b1010;
               2'b01:   w_out_next = 4'b1001;
               default: w_out_next = 4'b0000;
            endcase
         end
         ST_DANCE: begin
            case (w_step_next)
               2'd0:    w_out_next = 4'b1000;
               2'd1:    w_out_next = 4'b0010;
               2'd2:    w_out_next = 4'b0100;
               default: w_out_next = 4'b0001;
            endcase
         end
         default: w_out_next = 4'b0000;
      endcase
      if (w_brake_next) begin
         w_out_next[3] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_MANUAL;
         r_dir      <= 4'b0000;
         r_timeout  <= '0;
         r_step     <= 2'd0;
         r_step_tmr <= '0;
         r_out      <= 4'b0000;
         r_brake    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_dir      <= w_dir_next;
         r_timeout  <= w_timeout_next;
         r_step     <= w_step_next;
         r_step_tmr <= w_step_tmr_next;
         r_out      <= w_out_next;
         r_brake    <= w_brake_next;
      end
   end

   assign mv_fwd       = r_out[3];
   assign mv_back      = r_out[2];
   assign turn_left    = r_out[1];
   assign turn_right   = r_out[0];
   assign mode         = r_state;
   assign brake_active = r_brake;

endmodule

// File: doc/drive_cmd_arbiter.md
DRIVE_CMD_ARBITER -- requirements
Module: drive_cmd_arbiter

Interface
REQ-001 SHALL have parameter DANCE_STEP_CYCLES, default 50000000, clock cycles per dance step.
REQ-002 SHALL have parameter MANUAL_TIMEOUT_CYCLES, default 25000000, cycles without a remote command before manual motion stops.
REQ-003 SHALL have parameter BRAKE_HOLD_CYCLES, default 10000000, cycles the brake is held after the obstacle clears (used only under BRAKE_HOLD_EN).
REQ-004 SHALL have port: clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: ir_valid  input  1  one-cycle pulse qualifying ir_cmd.
REQ-007 SHALL have port: ir_cmd  input  7  {stop, fwd, back, left, right, auto, dance}, bit 6 = stop, bit 0 = dance.
REQ-008 SHALL have port: car_break_signal  input  1  obstacle sensor, 1 = obstacle ahead.
REQ-009 SHALL have port: left_line_signal / right_line_signal  input  1 each  line sensors, 1 = line detected.
REQ-010 SHALL have port: mv_fwd, mv_back, turn_left, turn_right  output  1 each  registered drive requests to the car datapath.
REQ-011 SHALL have port: mode  output  2  00 MANUAL, 01 AUTO, 10 DANCE.
REQ-012 SHALL have port: brake_active  output  1  forward motion currently suppressed by obstacle.

Function
REQ-013 SHALL implement FSM states MANUAL, AUTO, DANCE; mode output equals the current state encoding.
REQ-014 SHALL decode ir_cmd only when ir_valid=1; priority stop > auto > dance > direction bits.
REQ-015 SHALL on stop: go to MANUAL, clear latched direction, dance step counter, step timer and timeout counter.
REQ-016 SHALL on auto: MANUAL/DANCE -> AUTO, AUTO -> MANUAL; on dance: MANUAL/AUTO -> DANCE, DANCE -> MANUAL; entering DANCE restarts at step 0 with timer cleared.
REQ-017 SHALL in MANUAL latch direction on each valid direction command: fwd beats back, left beats right; a command with fwd/back both 0 clears motion; turn bits latched together with motion bits.
REQ-018 SHALL in MANUAL clear all latched direction outputs when the timeout counter reaches MANUAL_TIMEOUT_CYCLES-1; counter reloads to 0 on every ir_valid.
REQ-019 SHALL in AUTO drive: no line -> fwd; left only -> fwd+left; right only -> fwd+right; both -> all outputs 0.
REQ-020 SHALL in DANCE cycle steps 0 fwd, 1 left, 2 back, 3 right (single output high), advancing when step timer reaches DANCE_STEP_CYCLES-1, wrapping 3 -> 0.
REQ-021 SHALL force mv_fwd=0 and brake_active=1 whenever the brake condition holds, in every mode; mv_back, turn bits and FSM state unaffected.
REQ-022 SHALL register all outputs: one-cycle latency from any input change to output change.
REQ-023 SHALL never assert mv_fwd and mv_back together, nor turn_left and turn_right together.
REQ-024 SHALL ignore direction bits received in AUTO or DANCE (no latching).

Reset
REQ-025 SHALL on reset=0 immediately set state MANUAL, all outputs 0, all counters and latches 0.
REQ-026 SHALL honour reset mid-dance or mid-hold with no residual state after release.

Configuration
REQ-027 SHALL with BRAKE_HOLD_EN defined keep the brake condition asserted for BRAKE_HOLD_CYCLES cycles after car_break_signal falls; a new rise restarts the hold.
REQ-028 SHALL without BRAKE_HOLD_EN define the brake condition as car_break_signal alone, releasing one cycle after it falls.

Verification
REQ-029 SHALL cover: reset low -> all outputs 0, mode=00; ir_cmd=0100000 valid -> mv_fwd=1 next cycle.
REQ-030 SHALL cover: MANUAL_TIMEOUT_CYCLES=8, one fwd command, no further valid -> mv_fwd drops after 8 cycles.
REQ-031 SHALL cover: ir_cmd=0000010 -> mode=01; left_line=1,right_line=0 -> mv_fwd=1,turn_left=1; both lines 1 -> all 0.
REQ-032 SHALL cover: DANCE_STEP_CYCLES=4, dance command -> fwd,left,back,right each 4 cycles, then fwd again.
REQ-033 SHALL cover: ir_cmd=1000011 valid in DANCE -> mode=00, outputs 0 (stop wins).
REQ-034 SHALL cover: car_break_signal=1 during MANUAL fwd -> mv_fwd=0, brake_active=1; with BRAKE_HOLD_EN and BRAKE_HOLD_CYCLES=5, release 5 cycles after fall.
